// File: rtl/phas_gen_pkg.sv
// phas_gen_pkg: shared constants and FSM state type for the two-channel
// phase-lagged square-wave generator (phas_sig_gen) and its delay divider.
package phas_gen_pkg;

   // Default widths of period/counter/delay and of the phase input.
   localparam int CNT_W_DFLT    = 32;
   localparam int PH_W_DFLT     = 9;

   // Degrees in one full waveform period (the DEG_FULL constant).
   localparam int DEG_FULL_DFLT = 360;

   // Config/apply sequencer states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,   // no waveform applied yet, waiting for a config
      CALC = 2'd1,   // dividing period*phase by DEG_FULL
      PEND = 2'd2,   // delay ready, waiting for a safe moment to apply
      RUN  = 2'd3    // waveform applied, ready for a new config
   } state_t;

endpackage

// File: rtl/phas_delay_div.sv
// phas_delay_div: start/done restoring divider with fixed latency.
// Converts period*phase into a cycle delay by dividing by DEG_FULL.
// The first quotient bit retires on the start edge, and one more bit
// retires per clock after that. done is high in the cycle whose closing
// edge retires the last bit. quotient is valid from the cycle after done
// and holds until the next start.
import phas_gen_pkg::*;

module phas_delay_div #(
   parameter int CNT_W = CNT_W_DFLT,
   parameter int PH_W  = PH_W_DFLT,
   parameter int DVD_W = CNT_W + PH_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DVD_W-1:0] dividend,
   input  logic [PH_W-1:0]  divisor,
   output logic             done,
   output logic [CNT_W-1:0] quotient
);

   localparam int SW = $clog2(DVD_W + 1);
   localparam logic [SW-1:0] LAST_STEP = SW'(DVD_W - 1);

   logic [DVD_W-1:0] dvd_q;      // dividend bits not yet shifted in (MSB first)
   logic [PH_W-1:0]  rem_q;      // partial remainder, always < divisor
   logic [PH_W-1:0]  dsr_q;      // divisor held for the whole division
   logic [CNT_W-1:0] quo_q;      // quotient; it always fits CNT_W bits
   logic [SW-1:0]    step_q;     // quotient bits retired so far
   logic             busy_q;

   logic [PH_W:0]    trial;
   logic [PH_W-1:0]  dsr_sel;
   logic             fits;
   logic [PH_W-1:0]  rem_nx;
   logic [DVD_W-1:0] dvd_nx;
   logic [CNT_W-1:0] quo_nx;

   // One restoring step. On start it works on the fresh operands; after
   // that it works on the registered partial results.
   always_comb begin
      trial   = '0;
      dsr_sel = dsr_q;
      fits    = 1'b0;
      rem_nx  = rem_q;
      dvd_nx  = dvd_q;
      quo_nx  = quo_q;
      if (start) begin
         trial   = {{PH_W{1'b0}}, dividend[DVD_W-1]};
         dsr_sel = divisor;
         dvd_nx  = {dividend[DVD_W-2:0], 1'b0};
      end else begin
         trial   = {rem_q, dvd_q[DVD_W-1]};
         dvd_nx  = {dvd_q[DVD_W-2:0], 1'b0};
      end
      fits   = (trial >= {1'b0, dsr_sel});
      rem_nx = fits ? PH_W'(trial - {1'b0, dsr_sel}) : trial[PH_W-1:0];
      quo_nx = start ? {{(CNT_W-1){1'b0}}, fits} : {quo_q[CNT_W-2:0], fits};
   end

   // Operand/result registers and the fixed-length step counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd_q  <= '0;
         rem_q  <= '0;
         dsr_q  <= '0;
         quo_q  <= '0;
         step_q <= '0;
         busy_q <= 1'b0;
      end else if (start) begin
         dvd_q  <= dvd_nx;
         rem_q  <= rem_nx;
         dsr_q  <= divisor;
         quo_q  <= quo_nx;
         step_q <= SW'(1);
         busy_q <= 1'b1;
      end else if (busy_q) begin
         dvd_q  <= dvd_nx;
         rem_q  <= rem_nx;
         quo_q  <= quo_nx;
         step_q <= step_q + SW'(1);
         if (step_q == LAST_STEP) begin
            busy_q <= 1'b0;
         end
      end
   end

   assign done     = busy_q && (step_q == LAST_STEP);
   assign quotient = quo_q;

endmodule

// File: rtl/phas_sig_gen.sv
// phas_sig_gen: two-channel square-wave source. sig_A is the reference and
// sig_B lags it by a programmable phase (0..DEG_FULL-1 degrees) at a
// programmable period. New settings are converted into a cycle delay by
// phas_delay_div. They switch in only at a period boundary, so the outputs
// never show a runt pulse.
// Build option: define SYNC_OUT_EN to add the 'sync' output. It gives a
// one-cycle pulse at the start of every waveform period.
//
// Config handshake: a transfer happens on a rising clk edge where
// cfg_valid && cfg_ready. cfg_ready depends only on the state register and
// is high in IDLE and RUN. An illegal beat is still consumed: it produces a
// one-cycle cfg_err pulse and changes nothing else.
import phas_gen_pkg::*;

module phas_sig_gen #(
   parameter int CNT_W    = CNT_W_DFLT,
   parameter int PH_W     = PH_W_DFLT,
   parameter int DEG_FULL = DEG_FULL_DFLT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [PH_W-1:0]  cfg_phase,
   output logic             cfg_err,
   output logic             active,
   output logic             sig_A,
   output logic             sig_B,
`ifdef SYNC_OUT_EN
   output logic             sync,
`endif
   output state_t           dbg_state
);

   localparam int DVD_W = CNT_W + PH_W;
   localparam logic [PH_W-1:0] DEG_DIV = PH_W'(DEG_FULL);

   state_t           state, state_nx;

   logic [CNT_W-1:0] period_q;      // applied period P
   logic [CNT_W-1:0] half_q;        // applied high time H = P>>1
   logic [CNT_W-1:0] delay_q;       // applied sig_B lag D in cycles
   logic [CNT_W-1:0] cnt_q;         // position within the period, 0..P-1
   logic [CNT_W-1:0] new_period_q;  // accepted period waiting to be applied
   logic             active_q;
   logic             err_q;
   logic             a_q, b_q;
`ifdef SYNC_OUT_EN
   logic             sync_q;
`endif

   logic             take;
   logic             legal;
   logic             div_start;
   logic             div_done;
   logic [CNT_W-1:0] div_quo;
   logic [DVD_W-1:0] product;
   logic             step;
   logic             wrap;
   logic             apply;
   logic [CNT_W-1:0] cnt_b;

   assign cfg_ready = (state == IDLE) || (state == RUN);
   assign take      = cfg_valid && cfg_ready;
   assign legal     = (cfg_period >= CNT_W'(2)) && (cfg_phase < DEG_DIV);
   assign product   = DVD_W'(cfg_period) * DVD_W'(cfg_phase);

   // The waveform advances only while a config is applied and en is high.
   // This holds in every state, so the old waveform keeps running through
   // CALC and PEND.
   assign step      = active_q && en;
   assign wrap      = step && (cnt_q == period_q - CNT_W'(1));

   // sig_B's position in its own period: cnt delayed by D, modulo P.
   assign cnt_b     = (cnt_q >= delay_q) ? (cnt_q - delay_q)
                                         : (cnt_q + period_q - delay_q);

   phas_delay_div #(
      .CNT_W (CNT_W),
      .PH_W  (PH_W)
   ) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start),
      .dividend (product),
      .divisor  (DEG_DIV),
      .done     (div_done),
      .quotient (div_quo)
   );

   // Sequencer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state, divider start and the apply strobe.
   always_comb begin
      state_nx  = state;
      div_start = 1'b0;
      apply     = 1'b0;
      case (state)
         IDLE, RUN: begin
            if (take && legal) begin
               div_start = 1'b1;
               state_nx  = CALC;
            end
         end
         CALC: begin
            if (div_done) begin
               state_nx = PEND;
            end
         end
         PEND: begin
            // With nothing running there is no waveform to protect. Otherwise
            // wait for the P-1 -> 0 wrap so the switch lands on a boundary.
            if (!active_q || wrap) begin
               apply    = 1'b1;
               state_nx = RUN;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Capture the accepted period and flag rejected beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         new_period_q <= '0;
         err_q        <= 1'b0;
      end else begin
         err_q <= take && !legal;
         if (div_start) begin
            new_period_q <= cfg_period;
         end
      end
   end

   // Applied waveform parameters and the period counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_q <= '0;
         half_q   <= '0;
         delay_q  <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (apply) begin
         period_q <= new_period_q;
         half_q   <= new_period_q >> 1;
         delay_q  <= div_quo;
         cnt_q    <= '0;
         active_q <= 1'b1;
      end else if (step) begin
         cnt_q <= wrap ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // Registered outputs, one cycle behind cnt. They hold while frozen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= 1'b0;
         b_q <= 1'b0;
      end else if (step) begin
         a_q <= (cnt_q < half_q);
         b_q <= (cnt_b < half_q);
      end
   end

`ifdef SYNC_OUT_EN
   // Period-start marker, aligned with the registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 1'b0;
      end else begin
         sync_q <= step && (cnt_q == '0);
      end
   end

   assign sync = sync_q;
`endif

   assign cfg_err   = err_q;
   assign active    = active_q;
   assign sig_A     = a_q;
   assign sig_B     = b_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_phas_sig_gen.sv
// tb_phas_sig_gen: directed bench for phas_sig_gen. Inputs are driven on
// falling edges and outputs are sampled on falling edges.
module tb_phas_sig_gen;
   import phas_gen_pkg::*;

   localparam int CNT_W = 32;
   localparam int PH_W  = 9;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CNT_W-1:0] cfg_period;
   logic [PH_W-1:0]  cfg_phase;
   logic             cfg_err;
   logic             active;
   logic             sig_A;
   logic             sig_B;
   state_t           dbg_state;
`ifdef SYNC_OUT_EN
   logic             sync;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   phas_sig_gen #(
      .CNT_W    (CNT_W),
      .PH_W     (PH_W),
      .DEG_FULL (360)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_period (cfg_period),
      .cfg_phase  (cfg_phase),
      .cfg_err    (cfg_err),
      .active     (active),
      .sig_A      (sig_A),
      .sig_B      (sig_B),
`ifdef SYNC_OUT_EN
      .sync       (sync),
`endif
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      rst_n      = 1'b0;
      en         = 1'b0;
      cfg_valid  = 1'b0;
      cfg_period = '0;
      cfg_phase  = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // ---------------- driver tasks ----------------
   // One config beat. Returns on the falling edge after the transfer edge.
   task automatic send_cfg(input int p, input int ph);
      int guard;
      guard = 0;
      while (cfg_ready !== 1'b1 && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 3000) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_cfg_ready: got cfg_ready=%b expected 1 within 3000 cycles", cfg_ready);
      end
      cfg_period = CNT_W'(p);
      cfg_phase  = PH_W'(ph);
      cfg_valid  = 1'b1;
      @(negedge clk);
      cfg_valid  = 1'b0;
   endtask

   // Wait until the accepted config has been applied.
   task automatic wait_run();
      int guard;
      guard = 0;
      while (!(cfg_ready === 1'b1 && active === 1'b1 && dbg_state === RUN) && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 3000) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_run: got state=%0d active=%b expected RUN/1 within 3000 cycles", dbg_state, active);
      end
   endtask

   // Wait for a sig_A rise, then measure one full sig_A period: high time,
   // low time and the delay of the first sig_B rise relative to sig_A's rise.
   task automatic measure(output int a_hi, output int a_lo, output int b_lag, output bit to);
      int  t;
      int  t_fall;
      logic pa, pb;
      to = 1'b0; a_hi = -1; a_lo = -1; b_lag = -1; t_fall = -1;
      pa = sig_A; pb = sig_B; t = 0;
      while (1) begin
         @(negedge clk);
         if (!pa && sig_A) break;
         pa = sig_A; pb = sig_B; t++;
         if (t > 5000) begin to = 1'b1; return; end
      end
      if (!pb && sig_B) b_lag = 0;
      pa = sig_A; pb = sig_B; t = 0;
      while (1) begin
         @(negedge clk);
         t++;
         if (pa && !sig_A) t_fall = t;
         if (!pb && sig_B && b_lag < 0) b_lag = t;
         if (!pa && sig_A) begin
            a_hi = t_fall;
            a_lo = t - t_fall;
            break;
         end
         pa = sig_A; pb = sig_B;
         if (t > 5000) begin to = 1'b1; return; end
      end
   endtask

   // Align to a sig_A rising sample; to=1 if none came.
   task automatic wait_a_rise(output bit to);
      logic pa;
      to = 1'b1;
      pa = sig_A;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!pa && sig_A) begin to = 1'b0; break; end
         pa = sig_A;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_phase = '0;
      repeat (2) @(negedge clk);
      n_tests++; if (sig_A !== 1'b0 || sig_B !== 1'b0) begin n_fail++; $display("FAIL reset_sig: got A=%b B=%b expected 0 0", sig_A, sig_B); end
      n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", active); end
      n_tests++; if (cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg: got ready=%b err=%b expected 1 0", cfg_ready, cfg_err); end
      n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int low, a_hi, a_lo, b_lag;
      bit to;
      do_reset();
      en = 1'b1;
      send_cfg(1000, 90);
      low = 0;
      while (cfg_ready === 1'b0 && low < 200) begin
         low++;
         @(negedge clk);
      end
      n_tests++; if (low !== 41) begin n_fail++; $display("FAIL basic_ready_low: got %0d cycles expected 41", low); end
      n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL basic_active: got %b expected 1", active); end
      measure(a_hi, a_lo, b_lag, to);
      n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b expected 0", to); end
      n_tests++; if (a_hi !== 500 || a_lo !== 500) begin n_fail++; $display("FAIL basic_duty: got hi=%0d lo=%0d expected 500 500", a_hi, a_lo); end
      n_tests++; if (b_lag !== 250) begin n_fail++; $display("FAIL basic_lag: got %0d expected 250", b_lag); end
`ifdef SYNC_OUT_EN
      begin
         int pulses;
         pulses = 0;
         for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (sync === 1'b1) pulses++;
         end
         n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL basic_sync: got %0d pulses expected 1", pulses); end
      end
`endif
   endtask

   task automatic test_phase_0_180();
      int bad;
      send_cfg(1000, 0);
      wait_run();
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (sig_B !== sig_A) bad++;
      end
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL phase0_equal: got %0d differing cycles expected 0", bad); end
      send_cfg(1000, 180);
      wait_run();
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (sig_B !== ~sig_A) bad++;
      end
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL phase180_inverse: got %0d non-inverted cycles expected 0", bad); end
   endtask

   task automatic test_phase_359_p7();
      int a_hi, a_lo, b_lag;
      bit to;
      send_cfg(1000, 359);
      wait_run();
      measure(a_hi, a_lo, b_lag, to);
      n_tests++; if (to !== 1'b0 || a_hi !== 500 || a_lo !== 500) begin n_fail++; $display("FAIL p359_duty: got hi=%0d lo=%0d to=%b expected 500 500 0", a_hi, a_lo, to); end
      n_tests++; if (b_lag !== 997) begin n_fail++; $display("FAIL p359_lag: got %0d expected 997", b_lag); end
      send_cfg(7, 90);
      wait_run();
      measure(a_hi, a_lo, b_lag, to);
      n_tests++; if (to !== 1'b0 || a_hi !== 3 || a_lo !== 4) begin n_fail++; $display("FAIL p7_duty: got hi=%0d lo=%0d to=%b expected 3 4 0", a_hi, a_lo, to); end
      n_tests++; if (b_lag !== 1) begin n_fail++; $display("FAIL p7_lag: got %0d expected 1", b_lag); end
   endtask

   task automatic test_illegal();
      int a_hi, a_lo, b_lag;
      bit to;
      // phase out of range, then period too short; 7/90 stays running
      send_cfg(7, 360);
      n_tests++; if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL ill_phase_err: got err=%b ready=%b expected 1 1", cfg_err, cfg_ready); end
      n_tests++; if (dbg_state !== RUN) begin n_fail++; $display("FAIL ill_phase_state: got %0d expected %0d", dbg_state, RUN); end
      @(negedge clk);
      n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL ill_phase_pulse: got %b expected 0", cfg_err); end
      send_cfg(1, 90);
      n_tests++; if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL ill_p1_err: got err=%b ready=%b expected 1 1", cfg_err, cfg_ready); end
      @(negedge clk);
      n_tests++; if (cfg_err !== 1'b0 || dbg_state !== RUN) begin n_fail++; $display("FAIL ill_p1_pulse: got err=%b state=%0d expected 0 %0d", cfg_err, dbg_state, RUN); end
      measure(a_hi, a_lo, b_lag, to);
      n_tests++; if (to !== 1'b0 || a_hi !== 3 || a_lo !== 4 || b_lag !== 1) begin n_fail++; $display("FAIL ill_waveform: got hi=%0d lo=%0d lag=%0d expected 3 4 1", a_hi, a_lo, b_lag); end
   endtask

   task automatic test_reconfig_mid();
      int   t_r2, t_f2, t_b2, min_a, min_b, run_a, run_b;
      bit   to, seen_b;
      logic pa, pb;
      send_cfg(1000, 90);
      wait_run();
      wait_a_rise(to);
      n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL mid_align: got timeout=%b expected 0", to); end
      pa = sig_A; pb = sig_B; seen_b = 1'b0;
      run_a = 1; run_b = 1; min_a = 100000; min_b = 100000;
      t_r2 = -1; t_f2 = -1; t_b2 = -1;
      for (int t = 1; t <= 1800; t++) begin
         @(negedge clk);
         if (sig_A !== pa) begin
            if (run_a < min_a) min_a = run_a;
            run_a = 1;
            if (sig_A && t_r2 < 0) t_r2 = t;
            else if (!sig_A && t_r2 >= 0 && t_f2 < 0) t_f2 = t;
         end else begin
            run_a++;
         end
         if (sig_B !== pb) begin
            if (seen_b && run_b < min_b) min_b = run_b;
            seen_b = 1'b1;
            run_b = 1;
            if (sig_B && t_r2 >= 0 && t_b2 < 0) t_b2 = t;
         end else begin
            run_b++;
         end
         pa = sig_A; pb = sig_B;
         if (t == 100) begin
            cfg_period = CNT_W'(400); cfg_phase = PH_W'(45); cfg_valid = 1'b1;
         end
         if (t == 101) cfg_valid = 1'b0;
      end
      n_tests++; if (t_r2 !== 1000) begin n_fail++; $display("FAIL mid_old_period: got A rise at %0d expected 1000", t_r2); end
      n_tests++; if (t_f2 - t_r2 !== 200) begin n_fail++; $display("FAIL mid_new_high: got %0d expected 200", t_f2 - t_r2); end
      n_tests++; if (t_b2 - t_r2 !== 50) begin n_fail++; $display("FAIL mid_new_lag: got %0d expected 50", t_b2 - t_r2); end
      n_tests++; if (min_a < 200 || min_b < 200) begin n_fail++; $display("FAIL mid_runt: got min A=%0d B=%0d expected >=200", min_a, min_b); end
   endtask

   task automatic test_en_freeze();
      int   changes, t_a, t_b, a_hi, a_lo, b_lag;
      bit   to;
      logic pa, pb;
      send_cfg(1000, 90);
      wait_run();
      wait_a_rise(to);
      n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL freeze_align: got timeout=%b expected 0", to); end
      pa = sig_A; pb = sig_B; changes = 0; t_a = -1; t_b = -1;
      for (int t = 1; t <= 1200; t++) begin
         @(negedge clk);
         if (t > 200 && t <= 323 && (sig_A !== pa || sig_B !== pb)) changes++;
         if (!pa && sig_A && t_a < 0) t_a = t;
         if (!pb && sig_B && t_b < 0) t_b = t;
         pa = sig_A; pb = sig_B;
         if (t == 200) en = 1'b0;
         if (t == 323) en = 1'b1;
      end
      n_tests++; if (changes !== 0) begin n_fail++; $display("FAIL freeze_hold: got %0d output changes expected 0", changes); end
      n_tests++; if (t_b !== 373) begin n_fail++; $display("FAIL freeze_b_rise: got %0d expected 373", t_b); end
      n_tests++; if (t_a !== 1123) begin n_fail++; $display("FAIL freeze_a_rise: got %0d expected 1123", t_a); end
      measure(a_hi, a_lo, b_lag, to);
      n_tests++; if (to !== 1'b0 || a_hi !== 500 || a_lo !== 500 || b_lag !== 250) begin n_fail++; $display("FAIL freeze_after: got hi=%0d lo=%0d lag=%0d expected 500 500 250", a_hi, a_lo, b_lag); end
   endtask

   task automatic test_reset_calc();
      bit to;
      wait_a_rise(to);
      repeat (5) @(negedge clk);
      send_cfg(1000, 45);
      repeat (10) @(negedge clk);
      n_tests++; if (dbg_state !== CALC || sig_A !== 1'b1 || to !== 1'b0) begin n_fail++; $display("FAIL rcalc_pre: got state=%0d A=%b expected %0d 1", dbg_state, sig_A, CALC); end
      rst_n = 1'b0;
      #1;
      n_tests++; if (sig_A !== 1'b0 || sig_B !== 1'b0 || active !== 1'b0) begin n_fail++; $display("FAIL rcalc_out: got A=%b B=%b active=%b expected 0 0 0", sig_A, sig_B, active); end
      n_tests++; if (cfg_ready !== 1'b1 || dbg_state !== IDLE) begin n_fail++; $display("FAIL rcalc_state: got ready=%b state=%0d expected 1 %0d", cfg_ready, dbg_state, IDLE); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_phase = '0;
      test_reset();
      test_basic();
      test_phase_0_180();
      test_phase_359_p7();
      test_illegal();
      test_reconfig_mid();
      test_en_freeze();
      test_reset_calc();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
